intv2_sym_sched: RTL
====================

// Module: intv2_sym_sched
// PURPOSE
//  Per-frame symbol scheduler in front of the second-level interleaver of the OFDM TX chain.
//  Takes one frame command (modulation type, DATA symbol count) and gates the coded-bit stream
//  into the interleaver: first the SIGNAL symbol (48 bits, BPSK), then N DATA symbols of NCBPS bits each.
//  Drives the interleaver's sig_flag/Map_Type side-band and marks symbol and frame boundaries.
// PARAMETERS
//  SYM_W     10  width of DATA symbol count / index
//  SIG_BITS  48  coded bits in the SIGNAL symbol
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      reset, asynchronous, active-low
//  cfg_vld        in   1      frame command valid
//  cfg_rdy        out  1      frame command accepted when cfg_vld&cfg_rdy
//  cfg_map_type   in   2      DATA modulation: 0=48, 1=96, 2=192, 3=288 bits/symbol
//  cfg_n_sym      in   SYM_W  number of DATA symbols (0 = SIGNAL only)
//  up_din         in   1      coded bit from encoder/puncturer
//  up_din_vld     in   1      upstream valid
//  up_din_rdy     out  1      upstream ready
//  intv2_din      out  1      bit to interleaver
//  intv2_din_vld  out  1      valid to interleaver
//  intv2_din_rdy  in   1      interleaver input ready
//  intv2_sig_flag out  1      1 while the SIGNAL symbol is in flight
//  intv2_map_type out  2      modulation of the current symbol
//  sym_start      out  1      pulse: first beat of a symbol accepted
//  sym_last       out  1      high on the beat completing a symbol
//  frame_done     out  1      one-cycle pulse after the last beat of a frame
//  sym_idx        out  SYM_W  current DATA symbol index (0 during SIGNAL)
//  busy           out  1      high in any state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; cfg_rdy=1, up_din_rdy=0, intv2_din_vld=0, intv2_sig_flag=0,
//    intv2_map_type=2'b11, sym_start=0, sym_last=0, frame_done=0, sym_idx=0, busy=0; counters 0.
//  - FSM: IDLE -cfg_vld-> SIG -48th beat-> DATA (n_sym>0) or DONE (n_sym=0);
//    DATA -last beat of symbol n_sym-1-> DONE; DONE -> IDLE unconditionally (1 cycle).
//  - cfg_rdy=1 only in IDLE; map_type/n_sym captured into registers on acceptance; cfg ignored elsewhere.
//  - Beat = intv2_din_vld & intv2_din_rdy. In SIG/DATA: intv2_din=up_din,
//    intv2_din_vld=up_din_vld, up_din_rdy=intv2_din_rdy (combinational, zero latency).
//    In IDLE/DONE: intv2_din_vld=0, up_din_rdy=0.
//  - Bit counter (9 bit) increments per beat; symbol length L = 48 in SIG, NCBPS(map) in DATA;
//    at count L-1 with beat: sym_last=1, counter wraps to 0, sym_idx increments (DATA only).
//  - sym_start = beat & counter==0. sym_last is combinational, valid only with a beat.
//  - intv2_sig_flag and intv2_map_type registered: on cfg acceptance -> sig_flag=1, map=0;
//    on last SIG beat -> sig_flag=0, map=captured type; held through DATA; unchanged in DONE/IDLE.
//  - No beats lost or duplicated across symbol boundaries; stall (rdy=0) freezes all counters.
//  - frame_done asserted exactly in DONE. busy = (state!=IDLE).
//  - Reset mid-frame: everything returns to reset values immediately; partial frame discarded.
// CONFIGURATION
//  INTV2_SCHED_ABORT_EN defined: extra input abort (1 bit). abort=1 in SIG/DATA/DONE -> next
//    cycle IDLE, counters and sym_idx cleared, sig_flag=0, frame_done NOT pulsed; while
//    abort=1, intv2_din_vld and up_din_rdy forced 0 in the same cycle. abort in IDLE ignored.
//  Not defined: port absent, internal abort tied 0; behaviour as above.
// TESTING
//  1. cfg map=0, n_sym=0, continuous vld/rdy -> 48 beats, sig_flag=1 throughout,
//     sym_last on beat 48, frame_done 1 cycle later, then cfg_rdy=1.
//  2. cfg map=3, n_sym=2 -> 48 SIG + 288 + 288 beats; map_type=0 then 3 after beat 48;
//     sym_idx 0,1; three sym_start pulses, three sym_last pulses; frame_done once.
//  3. map=1, n_sym=3, intv2_din_rdy random 50% -> exactly 48+288 beats, bits pass in order,
//     counters frozen on stall cycles, no vld in IDLE/DONE.
//  4. cfg_vld held high during frame with different values -> not accepted until IDLE;
//     next frame uses new values; back-to-back frames with 2-cycle gap (DONE+IDLE) minimum.
//  5. rst_n asserted at DATA symbol 1 beat 100 -> all outputs at reset values; next frame normal.
//  6. (ABORT_EN) abort at SIG beat 20 -> vld drops same cycle, IDLE next cycle, no frame_done.

Source files
------------

// File: rtl/intv2_sym_sched.sv
// intv2_sym_sched
//   Per-frame symbol scheduler in front of the second-level interleaver. A frame
//   command (DATA modulation, DATA symbol count) is accepted in IDLE. The block then
//   gates the coded-bit stream through to the interleaver: first the 48-bit BPSK
//   SIGNAL symbol, then n_sym DATA symbols of NCBPS bits each.
//
//   Optional feature: define INTV2_SCHED_ABORT_EN to add the 'abort' input. It
//   drops the frame in flight and returns to IDLE without a frame_done pulse.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   abort               (INTV2_SCHED_ABORT_EN only) cancel the current frame
//   cfg_vld/cfg_rdy     frame command handshake; cfg_rdy high only in IDLE
//   cfg_map_type        DATA modulation: 0=48, 1=96, 2=192, 3=288 bits/symbol
//   cfg_n_sym           DATA symbol count (0 = SIGNAL only)
//   up_din/_vld/_rdy    coded-bit stream from encoder/puncturer
//   intv2_din/_vld/_rdy bit stream towards the interleaver
//   intv2_sig_flag      high while the SIGNAL symbol is in flight
//   intv2_map_type      modulation of the current symbol
//   sym_start/sym_last  first / final accepted beat of a symbol
//   frame_done          one cycle in DONE after the last beat of a frame
//   sym_idx             current DATA symbol index (0 during SIGNAL)
//   busy                high outside IDLE
module intv2_sym_sched #(
    parameter int unsigned SYM_W    = 10,
    parameter int unsigned SIG_BITS = 48
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef INTV2_SCHED_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cfg_vld,
    output logic             cfg_rdy,
    input  logic [1:0]       cfg_map_type,
    input  logic [SYM_W-1:0] cfg_n_sym,
    input  logic             up_din,
    input  logic             up_din_vld,
    output logic             up_din_rdy,
    output logic             intv2_din,
    output logic             intv2_din_vld,
    input  logic             intv2_din_rdy,
    output logic             intv2_sig_flag,
    output logic [1:0]       intv2_map_type,
    output logic             sym_start,
    output logic             sym_last,
    output logic             frame_done,
    output logic [SYM_W-1:0] sym_idx,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StSig, StData, StDone} state_e;

    localparam logic [8:0] SigLast = 9'(SIG_BITS - 1);

    function automatic logic [8:0] ncbps(input logic [1:0] m);
        logic [8:0] n;
        unique case (m)
            2'd0:    n = 9'd48;
            2'd1:    n = 9'd96;
            2'd2:    n = 9'd192;
            default: n = 9'd288;
        endcase
        return n;
    endfunction

    state_e           state_q, state_d;
    logic [8:0]       bit_cnt_q, bit_cnt_d;
    logic [SYM_W-1:0] sym_idx_q, sym_idx_d;
    logic [SYM_W-1:0] n_sym_q, n_sym_d;
    logic [1:0]       map_q, map_d;
    logic             sig_flag_q, sig_flag_d;
    logic [1:0]       map_type_q, map_type_d;

    logic             abort_int;
    logic             abort_act;
    logic             active;
    logic             beat;
    logic             cfg_acc;
    logic [8:0]       len_last;
    logic             last_data_sym;

`ifdef INTV2_SCHED_ABORT_EN
    assign abort_int = abort;
`else
    assign abort_int = 1'b0;
`endif

    // Abort has no effect in IDLE.
    assign abort_act = abort_int & (state_q != StIdle);

    // Zero-latency pass-through while a symbol is in flight.
    assign intv2_din     = up_din;
    assign intv2_din_vld = active & up_din_vld;
    assign up_din_rdy    = active & intv2_din_rdy;
    assign beat          = intv2_din_vld & intv2_din_rdy;
    assign cfg_acc       = cfg_vld & cfg_rdy;

    assign len_last      = (state_q == StSig) ? SigLast : ncbps(map_q) - 9'd1;
    assign sym_start     = beat & (bit_cnt_q == 9'd0);
    assign sym_last      = beat & (bit_cnt_q == len_last);
    // Only consulted in DATA, where n_sym_q is known to be non-zero.
    assign last_data_sym = (sym_idx_q == n_sym_q - SYM_W'(1));

    assign intv2_sig_flag = sig_flag_q;
    assign intv2_map_type = map_type_q;
    assign sym_idx        = sym_idx_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cfg_acc) state_d = StSig;
            StSig: begin
                if (sym_last) state_d = (n_sym_q == '0) ? StDone : StData;
            end
            StData: if (sym_last && last_data_sym) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_act) state_d = StIdle;
    end

    // FSM outputs
    always_comb begin
        cfg_rdy    = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        active     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cfg_rdy = 1'b1;
                busy    = 1'b0;
            end
            StSig, StData: active = ~abort_int;
            StDone: frame_done = ~abort_int;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        sym_idx_d  = sym_idx_q;
        n_sym_d    = n_sym_q;
        map_d      = map_q;
        sig_flag_d = sig_flag_q;
        map_type_d = map_type_q;

        if (cfg_acc) begin
            n_sym_d    = cfg_n_sym;
            map_d      = cfg_map_type;
            bit_cnt_d  = '0;
            sym_idx_d  = '0;
            sig_flag_d = 1'b1;
            map_type_d = 2'd0;
        end

        if (beat) begin
            bit_cnt_d = sym_last ? 9'd0 : bit_cnt_q + 9'd1;
            if (sym_last && (state_q == StData)) sym_idx_d = sym_idx_q + SYM_W'(1);
            // Side-band switches to the DATA modulation right after SIGNAL.
            if (sym_last && (state_q == StSig)) begin
                sig_flag_d = 1'b0;
                map_type_d = map_q;
            end
        end

        if (state_q == StDone) sym_idx_d = '0;

        if (abort_act) begin
            bit_cnt_d  = '0;
            sym_idx_d  = '0;
            sig_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            sym_idx_q  <= '0;
            n_sym_q    <= '0;
            map_q      <= '0;
            sig_flag_q <= 1'b0;
            map_type_q <= 2'b11;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            sym_idx_q  <= sym_idx_d;
            n_sym_q    <= n_sym_d;
            map_q      <= map_d;
            sig_flag_q <= sig_flag_d;
            map_type_q <= map_type_d;
        end
    end

endmodule
